// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done conversion bus for the sequential binary-to-BCD converter
interface bin2bcd_seq_if #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) ();
    logic                  start;
    logic [DATA_W-1:0]     data;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic [DIGITS-1:0]     lz_mask;

    modport master (
        output start, data,
        input  busy, done, bcd, ovf, lz_mask
    );

    modport slave (
        input  start, data,
        output busy, done, bcd, ovf, lz_mask
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - parametrised shift-and-add-3 binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_nxt;
    logic [SR_W-1:0]    sr, sr_adj, sr_shift;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;
    logic               last_iter;
    logic               ovf_final;
    logic [BCD_W-1:0]   bcd_final;
    logic [DIGITS-1:0]  lz_final;
    logic               all_zero;

    logic               busy_q, done_q, ovf_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [DIGITS-1:0]  lz_q;

    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONV;
            CONV:    if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: adjust every digit >= 5, then shift the whole {bcd, bin} register.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[DATA_W + 4*d +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*d +: 4] = sr[DATA_W + 4*d +: 4] + 4'd3;
        end
        sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
        ovf_final = sticky | sr_adj[SR_W-1];
        bcd_final = ovf_final ? {DIGITS{4'h9}} : sr_shift[SR_W-1:DATA_W];

        // Units digit is never blanked so a zero result still shows "0".
        lz_final = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero & (bcd_final[4*i +: 4] == 4'd0);
            lz_final[i] = all_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            lz_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr     <= {{BCD_W{1'b0}}, bus.data};
                        cnt    <= '0;
                        sticky <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                CONV: begin
                    sr     <= sr_shift;
                    cnt    <= cnt + CNT_W'(1);
                    sticky <= ovf_final;
                    if (last_iter) begin
                        bcd_q  <= bcd_final;
                        ovf_q  <= ovf_final;
                        lz_q   <= lz_final;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd     = bcd_q;
    assign bus.ovf     = ovf_q;
    assign bus.lz_mask = lz_q;
endmodule
